cache_wb_nway: RTL and testbench

Parametrised N-way set-associative write-back, write-allocate data cache for the 32-bit MIPS core; successor to the fixed 2-way cache.
Sits between the CPU load/store stage and the main-memory model.
Uses a full req/ready handshake on both sides, per-set round-robin replacement with invalid-way-first victim choice, and single-beat block transfers to memory.

---
 rtl/cache_wb_nway.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_cache_wb_nway.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_wb_nway.sv
// N-way set-associative write-back, write-allocate data cache with round-robin replacement.
// Define CACHE_FLUSH_EN to add the flush/flush_done dirty-line walk.
module cache_wb_nway #(
    parameter int ADDR_WIDTH      = 32,
    parameter int WORD_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_SETS        = 2048,
    parameter int NUM_WAYS        = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cpu_req,
    input  logic                                  cpu_we,
    input  logic [ADDR_WIDTH-1:0]                 cpu_addr,
    input  logic [WORD_WIDTH-1:0]                 cpu_wdata,
    output logic [WORD_WIDTH-1:0]                 cpu_rdata,
    output logic                                  cpu_ready,
    output logic                                  mem_req,
    output logic                                  mem_we,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    output logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] mem_wdata,
    input  logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] mem_rdata,
    input  logic                                  mem_ack
`ifdef CACHE_FLUSH_EN
    ,
    input  logic                                  flush,
    output logic                                  flush_done
`endif
);

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
    localparam int BLK_W = WORD_WIDTH * WORDS_PER_BLOCK;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef logic [WORDS_PER_BLOCK-1:0][WORD_WIDTH-1:0] blk_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        FILL,
        RESP
`ifdef CACHE_FLUSH_EN
        ,
        F_SCAN,
        F_WB,
        F_DONE
`endif
    } state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]                 tag_q  [NUM_SETS][NUM_WAYS];
    blk_t                             data_q [NUM_SETS][NUM_WAYS];
    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, dirty_q;
    logic [NUM_SETS-1:0][WAY_W-1:0]    rr_q;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic [WAY_W-1:0]      victim_q;
    logic                  by_rr_q;
    logic [WORD_WIDTH-1:0] resp_q;
    logic                  mem_req_q, mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [BLK_W-1:0]      mem_wdata_q;

    logic [OFF_W-1:0]      off;
    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [ADDR_WIDTH-1:0] req_blk;
    logic                  hit, inv_found, vic_dirty, accept;
    logic [WAY_W-1:0]      hit_way, inv_way, victim;
    logic [WORD_WIDTH-1:0] hit_word;
    blk_t                  fill_blk;
    logic                  unused_byte;

    assign off     = addr_q[OFF_W+1:2];
    assign idx     = addr_q[OFF_W+2 +: IDX_W];
    assign tag     = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign req_blk = {addr_q[ADDR_WIDTH-1:OFF_W+2], {(OFF_W+2){1'b0}}};
    assign unused_byte = ^addr_q[1:0];

    // Lowest way wins both the hit search and the invalid-way search.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim    = inv_found ? inv_way : rr_q[idx];
        vic_dirty = valid_q[idx][victim] && dirty_q[idx][victim];
        hit_word  = data_q[idx][hit_way][off];
        fill_blk  = mem_rdata;
        if (we_q) fill_blk[off] = wdata_q;
    end

`ifdef CACHE_FLUSH_EN
    logic [IDX_W-1:0] fset_q, fset_nx;
    logic [WAY_W-1:0] fway_q, fway_nx;
    logic             f_dirty, f_last;

    always_comb begin
        f_dirty = valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q];
        f_last  = (fset_q == IDX_W'(NUM_SETS - 1)) &&
                  (fway_q == WAY_W'(NUM_WAYS - 1));
        fset_nx = fset_q;
        fway_nx = fway_q + 1'b1;
        if (fway_q == WAY_W'(NUM_WAYS - 1)) begin
            fway_nx = '0;
            fset_nx = fset_q + 1'b1;
        end
    end

    assign accept = cpu_req && !flush;
`else
    assign accept = cpu_req;
`endif

    always_comb begin
        state_d   = state_q;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
`ifdef CACHE_FLUSH_EN
        flush_done = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = LOOKUP;
`ifdef CACHE_FLUSH_EN
                if (flush) state_d = F_SCAN;
`endif
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = we_q ? wdata_q : hit_word;
                    state_d   = IDLE;
                end else if (vic_dirty) begin
                    state_d = WB;
                end else begin
                    state_d = FILL;
                end
            end
            WB:   if (mem_ack) state_d = FILL;
            FILL: if (mem_ack) state_d = RESP;
            RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = resp_q;
                state_d   = IDLE;
            end
`ifdef CACHE_FLUSH_EN
            F_SCAN: begin
                if (f_dirty) state_d = F_WB;
                else if (f_last) state_d = F_DONE;
            end
            F_WB: if (mem_ack) state_d = f_last ? F_DONE : F_SCAN;
            F_DONE: begin
                flush_done = 1'b1;
                state_d    = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            rr_q        <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            victim_q    <= '0;
            by_rr_q     <= 1'b0;
            resp_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef CACHE_FLUSH_EN
            fset_q      <= '0;
            fway_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                    end
`ifdef CACHE_FLUSH_EN
                    if (flush) begin
                        fset_q <= '0;
                        fway_q <= '0;
                    end
`endif
                end
                LOOKUP: begin
                    if (hit) begin
                        if (we_q) dirty_q[idx][hit_way] <= 1'b1;
                    end else begin
                        victim_q  <= victim;
                        by_rr_q   <= !inv_found;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= vic_dirty;
                        if (vic_dirty) begin
                            mem_addr_q  <= {tag_q[idx][victim], idx,
                                            {(OFF_W+2){1'b0}}};
                            mem_wdata_q <= data_q[idx][victim];
                        end else begin
                            mem_addr_q <= req_blk;
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= req_blk;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        mem_req_q                <= 1'b0;
                        valid_q[idx][victim_q]   <= 1'b1;
                        dirty_q[idx][victim_q]   <= we_q;
                        resp_q                   <= fill_blk[off];
                        if (by_rr_q) begin
                            rr_q[idx] <= (NUM_WAYS == 1) ? '0 : rr_q[idx] + 1'b1;
                        end
                    end
                end
`ifdef CACHE_FLUSH_EN
                F_SCAN: begin
                    if (f_dirty) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {tag_q[fset_q][fway_q], fset_q,
                                        {(OFF_W+2){1'b0}}};
                        mem_wdata_q <= data_q[fset_q][fway_q];
                    end else if (!f_last) begin
                        fset_q <= fset_nx;
                        fway_q <= fway_nx;
                    end
                end
                F_WB: begin
                    if (mem_ack) begin
                        mem_req_q                <= 1'b0;
                        dirty_q[fset_q][fway_q]  <= 1'b0;
                        if (!f_last) begin
                            fset_q <= fset_nx;
                            fway_q <= fway_nx;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Line storage carries no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (state_q == LOOKUP && hit && we_q) begin
            data_q[idx][hit_way][off] <= wdata_q;
        end
        if (state_q == FILL && mem_ack) begin
            data_q[idx][victim_q] <= fill_blk;
            tag_q[idx][victim_q]  <= tag;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_wb_nway.sv
// Scoreboard bench for cache_wb_nway: golden word memory, backing DRAM model
// and a queue of expected memory transactions checked by the responder.
module tb_cache_wb_nway;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req, cpu_we, cpu_ready;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         mem_req, mem_we, mem_ack;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
`ifdef CACHE_FLUSH_EN
    logic         flush, flush_done;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } mtx_t;

    mtx_t        exp_mem_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] dram [logic [31:0]];
    logic [31:0] gm   [logic [31:0]];

    always #5 clk = ~clk;

    cache_wb_nway dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef CACHE_FLUSH_EN
        ,
        .flush     (flush),
        .flush_done(flush_done)
`endif
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        logic [31:0] r;
        if (a < 32'h20) r = {30'd0, a[3:2]} + 32'd1;
        else r = a ^ 32'h5A5A_0000;
        return r;
    endfunction

    function automatic logic [31:0] dram_rd(input logic [31:0] a);
        return dram.exists(a) ? dram[a] : init_word(a);
    endfunction

    function automatic logic [31:0] gm_rd(input logic [31:0] a);
        return gm.exists(a) ? gm[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ta(input int t, input logic [31:0] low);
        return (32'(t) << 15) | low;
    endfunction

    task automatic push_fill(input logic [31:0] a);
        mtx_t e;
        e.we = 1'b0;
        e.addr = a & ~32'hF;
        e.wdata = '0;
        exp_mem_q.push_back(e);
    endtask

    task automatic push_wb(input logic [31:0] a);
        mtx_t e;
        e.we = 1'b1;
        e.addr = a & ~32'hF;
        for (int i = 0; i < 4; i++) e.wdata[i*32 +: 32] = gm_rd(e.addr + 32'(4*i));
        exp_mem_q.push_back(e);
    endtask

    // Memory responder: checks each new request against the expected queue.
    initial begin
        int   cnt;
        mtx_t e;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (mem_req) begin
                if (cnt == 0) begin
                    tests++;
                    if (exp_mem_q.size() == 0) begin
                        fails++;
                        $display("FAIL mem_unexpected: got we=%0b addr=%h, required no request",
                                 mem_we, mem_addr);
                    end else begin
                        e = exp_mem_q.pop_front();
                        if (mem_we !== e.we || mem_addr !== e.addr ||
                            (e.we && mem_wdata !== e.wdata)) begin
                            fails++;
                            $display("FAIL mem_txn: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                                     mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                        end
                    end
                end
                cnt++;
                if (cnt == LAT) begin
                    for (int i = 0; i < 4; i++) begin
                        if (mem_we) dram[mem_addr + 32'(4*i)] = mem_wdata[i*32 +: 32];
                        else mem_rdata[i*32 +: 32] = dram_rd(mem_addr + 32'(4*i));
                    end
                    mem_ack = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic cpu_op(input logic we, input logic [31:0] a,
                          input logic [31:0] d, input int exp_lat,
                          input string nm);
        int lat;
        logic [31:0] exp;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        if (!we) exp_rd_q.push_back(gm_rd(a));
        else gm[a] = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_ready && lat < 400);
        cpu_req = 1'b0;
        tests++;
        if (!cpu_ready) begin
            fails++;
            $display("FAIL %s_ready: got no cpu_ready in %0d cycles, required a pulse", nm, lat);
            if (!we) void'(exp_rd_q.pop_front());
            return;
        end
        if (!we) begin
            exp = exp_rd_q.pop_front();
            tests++;
            if (cpu_rdata !== exp) begin
                fails++;
                $display("FAIL %s_rdata: got %h, required %h", nm, cpu_rdata, exp);
            end
        end
        if (exp_lat >= 0) begin
            tests++;
            if (lat != exp_lat) begin
                fails++;
                $display("FAIL %s_latency: got %0d, required %0d", nm, lat, exp_lat);
            end
        end
    endtask

    task automatic check_drained(input string nm);
        tests++;
        if (exp_mem_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drained: got %0d pending mem txns, required 0", nm, exp_mem_q.size());
            exp_mem_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests += 6;
        if (cpu_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b, required 0", cpu_ready); end
        if (cpu_rdata !== 32'd0) begin fails++; $display("FAIL rst_rdata: got %h, required 0", cpu_rdata); end
        if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req: got %b, required 0", mem_req); end
        if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_mem_we: got %b, required 0", mem_we); end
        if (mem_addr !== 32'd0) begin fails++; $display("FAIL rst_mem_addr: got %h, required 0", mem_addr); end
        if (mem_wdata !== 128'd0) begin fails++; $display("FAIL rst_mem_wdata: got %h, required 0", mem_wdata); end
    endtask

    task automatic test_fill_hit();
        push_fill(32'h14);
        cpu_op(1'b0, 32'h14, 32'h0, -1, "fill_load");
        @(negedge clk);
        cpu_op(1'b0, 32'h14, 32'h0, 1, "hit_load");
        @(negedge clk);
        cpu_op(1'b0, 32'h10, 32'h0, 1, "hit_load_w0");
        check_drained("fill_hit");
    endtask

    task automatic test_store_wb();
        @(negedge clk);
        cpu_op(1'b1, 32'h14, 32'hDEAD_BEEF, 1, "store_hit");
        push_fill(ta(1, 32'h14));
        cpu_op(1'b0, ta(1, 32'h14), 32'h0, -1, "way1_fill");
        push_wb(32'h10);
        push_fill(ta(2, 32'h14));
        cpu_op(1'b0, ta(2, 32'h14), 32'h0, -1, "evict_dirty");
        check_drained("store_wb");
    endtask

    task automatic test_store_miss();
        push_fill(32'h40);
        cpu_op(1'b1, 32'h40, 32'h55, -1, "store_miss");
        @(negedge clk);
        cpu_op(1'b0, 32'h40, 32'h0, 1, "store_miss_load");
        push_fill(ta(1, 32'h40));
        cpu_op(1'b0, ta(1, 32'h40), 32'h0, -1, "set4_way1");
        push_wb(32'h40);
        push_fill(ta(2, 32'h40));
        cpu_op(1'b0, ta(2, 32'h40), 32'h0, -1, "set4_evict");
        check_drained("store_miss");
    endtask

    task automatic test_round_robin();
        for (int t = 0; t < 5; t++) begin
            if (t >= 2) push_wb(ta(t - 2, 32'h80));
            push_fill(ta(t, 32'h80));
            cpu_op(1'b1, ta(t, 32'h80), 32'hA000_0000 + 32'(t), -1, "rr_store");
        end
        check_drained("round_robin");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cpu_op(1'b0, ta(3, 32'h80), 32'h0, 1, "b2b_first");
        cpu_op(1'b0, ta(4, 32'h80), 32'h0, 2, "b2b_second");
        cpu_op(1'b1, ta(4, 32'h84), 32'h77, 2, "b2b_store");
        cpu_op(1'b0, ta(4, 32'h84), 32'h0, 2, "b2b_readback");
        check_drained("back_to_back");
    endtask

    task automatic test_reset_mid_wb();
        int n;
        push_fill(ta(0, 32'hC0));
        cpu_op(1'b1, ta(0, 32'hC0), 32'h1111, -1, "mid_st0");
        push_fill(ta(1, 32'hC0));
        cpu_op(1'b1, ta(1, 32'hC0), 32'h2222, -1, "mid_st1");
        push_wb(ta(0, 32'hC0));
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = ta(2, 32'hC0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req && mem_we) && n < 50);
        tests++;
        if (!(mem_req && mem_we)) begin
            fails++;
            $display("FAIL mid_wb_seen: got mem_req=%b mem_we=%b, required 1 1", mem_req, mem_we);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests += 2;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL mid_rst_mem_req: got %b, required 0", mem_req); end
        if (cpu_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready: got %b, required 0", cpu_ready); end
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        gm = dram;
        check_drained("mid_wb");
        @(negedge clk);
        push_fill(ta(0, 32'hC0));
        cpu_op(1'b0, ta(0, 32'hC0), 32'h0, -1, "post_rst_miss");
        check_drained("post_rst");
    endtask

`ifdef CACHE_FLUSH_EN
    task automatic test_flush();
        int n;
        push_fill(32'h30);
        cpu_op(1'b1, 32'h30, 32'h3333, -1, "fl_set3");
        push_fill(32'h70);
        cpu_op(1'b1, 32'h74, 32'h7777, -1, "fl_set7");
        push_wb(32'h30);
        push_wb(32'h70);
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            n = 0;
            while (!flush_done && n < 20000) begin
                @(negedge clk);
                n++;
            end
            tests++;
            if (!flush_done) begin
                fails++;
                $display("FAIL flush_done_%0d: got no pulse in %0d cycles, required a pulse", pass, n);
            end
            @(negedge clk);
            tests++;
            if (flush_done !== 1'b0) begin
                fails++;
                $display("FAIL flush_pulse_%0d: got %b one cycle later, required 0", pass, flush_done);
            end
            check_drained("flush");
        end
    endtask
`endif

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish by 600us, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
`ifdef CACHE_FLUSH_EN
        flush = 1'b0;
`endif
        test_reset();
        test_fill_hit();
        test_store_wb();
        test_store_miss();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_wb();
`ifdef CACHE_FLUSH_EN
        test_flush();
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
